banked_mem_ctrl: RTL
====================

# banked_mem_ctrl

Parametrised banked single-port-write / registered-read memory with a self-clearing initialisation sweep, sitting in the `demo_memory` area as the successor to the fixed 4×256×8 banked memory. Upper address bits select a bank and lower bits index within it. After reset, or on request, every location is cleared by a hardware sweep before traffic is accepted. An optional formal shadow-check is compiled in for SymbiYosys runs.

## Interface
- `DATA_W`, 8, word width in bits
- `ADDR_W`, 10, full address width
- `NUM_BANKS`, 4, bank count; power of two, at least 2
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `wen` input 1 — write strobe; sampled only when `ready`=1
- `wdata` input DATA_W — write data
- `addr` input ADDR_W — shared read/write address
- `ren` input 1 — read strobe; sampled only when `ready`=1
- `clr` input 1 — synchronous request to re-run the clear sweep
- `rdata` output DATA_W — read data, registered
- `rvalid` output 1 — one-cycle pulse qualifying `rdata`
- `ready` output 1 — high in RUN; accepts `wen`/`ren`
- `init_busy` output 1 — high in INIT

## Operation
- BANK_BITS = log2(NUM_BANKS); bank = addr[ADDR_W-1 -: BANK_BITS]; index = addr[ADDR_W-BANK_BITS-1:0]; BANK_DEPTH = 2^(ADDR_W-BANK_BITS).
- States:
  - INIT: every cycle writes 0 at `sweep_idx` in all banks in parallel, then increments `sweep_idx`. Transition to RUN on the edge where `sweep_idx`==BANK_DEPTH-1.
  - RUN: on `clr`=1, go to INIT with `sweep_idx`=0. `clr` is ignored in INIT; it does not restart the sweep.
- Write: `wen` in RUN writes `wdata` into the selected bank/index at that edge. Exactly one bank is written.
- Read: `ren` in RUN captures the selected word into `rdata` and sets `rvalid`=1 for the next cycle only.
- Same-cycle `wen` and `ren` to the same address forwards: `rdata` = new `wdata`. To different addresses, both operations complete independently.
- `wen`, `ren` and `clr` in the same RUN cycle: the write and read complete, then the block enters INIT.
- In INIT, `wen` and `ren` are dropped with no effect, and `rvalid` stays 0.
- `rdata` holds its last value when `rvalid`=0.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `ready`=0, `init_busy`=1, state=INIT, `sweep_idx`=0. Memory contents are undefined until the sweep completes.
- Asserting `rst_n` mid-sweep or mid-read aborts immediately. A pending `rvalid` is lost, and the sweep restarts from index 0 after release.
- The sweep takes exactly BANK_DEPTH rising edges after `rst_n` release, i.e. 256 with the defaults. `ready` rises after the 256th edge.
- `clr` accepted at edge N: `ready`=0 from N, and `ready`=1 again after edge N+BANK_DEPTH.
- Read latency is 1: `ren` at edge N gives `rdata`/`rvalid` valid from N until N+1.
- Back-to-back reads sustain one per cycle, with `rvalid` held high continuously.

## Configuration
- `BANKED_MEM_CTRL_FORMAL_EN` defined:
  - adds an `anyconst` shadow address `test_addr` with `test_data` and `test_data_valid` registers;
  - asserts that a RUN read of `test_addr` after a tracked write returns `test_data`, and after any completed sweep returns 0;
  - asserts `ready` == !`init_busy`, and that `rvalid` is never set in the cycle after an INIT cycle.
- Undefined: no formal code; ports and behaviour are identical.

## Structure
- `banked_mem_pkg` holds:
  - the state enum `{ST_INIT, ST_RUN}`;
  - the `clog2`-based helper functions for BANK_BITS and BANK_DEPTH.
- Sub-module `banked_mem_bank`: one DATA_W × BANK_DEPTH array with a write port and a combinational read port. It is instantiated NUM_BANKS times via `generate`.
- Top level holds the FSM, sweep counter, bank decode, forwarding mux and output registers.

## Test plan
- Reset, then idle for 256 cycles → `init_busy`=1 and `ready`=0 throughout; `ready`=1 after the 256th edge; reading 0x000, 0x080, 0x180 and 0x3FF all return 0x00.
- Write 0xF7 @0x280, next cycle read 0x280 → `rvalid`=1 one cycle later with `rdata`=0xF7; read 0x080 (same index, bank 0) → 0x00.
- Same-cycle `wen`+`ren` at 0x155, `wdata`=0xA5 → `rdata`=0xA5 next cycle; a later read of 0x155 → 0xA5.
- Write 0x29 @0x280, pulse `clr`, drive `ren`/`wen` during the 256-cycle INIT → no `rvalid`, no writes; after `ready`, read 0x280 → 0x00.
- Assert `rst_n` low on the cycle after a `ren` → `rvalid`=0 and `rdata`=0 immediately; the sweep restarts from 0 and completes after 256 edges.
- With `NUM_BANKS`=8, `DATA_W`=16: write 0xBEEF @0x3E0 (bank 7, index 0x60) → read returns 0xBEEF; the sweep takes 128 edges.

Source files
------------

// File: rtl/banked_mem_pkg.sv
// Shared types and sizing helpers for the banked memory controller.
package banked_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int bank_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int bank_depth(input int addr_w, input int num_banks);
    return 1 << (addr_w - $clog2(num_banks));
  endfunction

endpackage

// File: rtl/banked_mem_bank.sv
// One memory bank: synchronous write port, combinational read port.
module banked_mem_bank #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/banked_mem_ctrl.sv
// Banked memory with hardware clear sweep after reset or on clr.
// Optional shadow-address formal checks: define BANKED_MEM_CTRL_FORMAL_EN.
module banked_mem_ctrl
  import banked_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              init_busy
);

  localparam int BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int IDX_W      = ADDR_W - BANK_BITS;
  localparam int BANK_DEPTH = bank_depth(ADDR_W, NUM_BANKS);

  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic              run;
  logic [BANK_BITS-1:0] bank_sel;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [NUM_BANKS-1:0] bank_we;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0] rd_word;

  assign run       = (state == ST_RUN);
  assign ready     = run;
  assign init_busy = !run;
  assign bank_sel  = addr[ADDR_W-1 -: BANK_BITS];
  assign idx       = addr[IDX_W-1:0];

  // The sweep shares the write port: all banks are cleared in parallel at sweep_idx.
  assign bank_addr  = run ? idx : sweep_idx;
  assign bank_wdata = run ? wdata : '0;

  always_comb begin
    bank_we = '0;
    if (!run)
      bank_we = '1;
    else if (wen)
      bank_we[bank_sel] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    banked_mem_bank #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .waddr(bank_addr),
      .wdata(bank_wdata),
      .raddr(idx),
      .rdata(bank_rdata[b])
    );
  end

  // Address is shared, so a simultaneous write always targets the word being read.
  assign rd_word = wen ? wdata : bank_rdata[bank_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
    end else begin
      rvalid <= run && ren;
      if (run && ren) rdata <= rd_word;
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + IDX_W'(1);
          if (sweep_idx == IDX_W'(BANK_DEPTH - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (clr) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef BANKED_MEM_CTRL_FORMAL_EN
  (* anyconst *) logic [ADDR_W-1:0] test_addr;
  logic [DATA_W-1:0] test_data;
  logic              test_data_valid;
  logic              chk_pending;
  logic [DATA_W-1:0] chk_expect;
  logic              was_init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_data       <= '0;
      test_data_valid <= 1'b0;
      chk_pending     <= 1'b0;
      chk_expect      <= '0;
      was_init        <= 1'b1;
    end else begin
      was_init    <= !run;
      chk_pending <= run && ren && (addr == test_addr) && test_data_valid;
      if (run && ren && (addr == test_addr))
        chk_expect <= wen ? wdata : test_data;
      if (!run) begin
        test_data       <= '0;
        test_data_valid <= (sweep_idx == IDX_W'(BANK_DEPTH - 1));
      end else if (wen && (addr == test_addr)) begin
        test_data       <= wdata;
        test_data_valid <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (ready == !init_busy);
      if (chk_pending) assert (rdata == chk_expect);
      if (was_init) assert (!rvalid);
    end
  end
`endif

endmodule
